// File: rtl/uart_word_transmitter.sv
// uart_word_transmitter
//   8N1 UART transmitter for the return path of the ICCM programming link.
//   32-bit words enter a small FIFO through a valid/ready port and are sent
//   as BYTES_PER_WORD bytes, low byte first, each byte framed as one start
//   bit (0), eight data bits LSB first and one stop bit (1).
//   The bit period comes from clks_per_bit_i at run time and is captured at
//   the start of every byte.
// Ports
//   clk_i           system clock
//   rst_i           synchronous reset, active-high; flushes FIFO, line goes high
//   clks_per_bit_i  clk_i cycles per UART bit (0 behaves as 1)
//   tx_valid_i      tx_word_i holds a word to send
//   tx_word_i       word to send
//   tx_ready_o      FIFO can accept a word (not full)
//   tx_serial_o     UART line, idles high
//   tx_active_o     a frame is in progress (START/DATA/STOP)
//   tx_done_o       1-cycle pulse after the last stop bit of a word
//   fifo_level_o    words held in the FIFO (excludes the word being shifted)
//   state_o         current FSM state, for debug and checkers
module uart_word_transmitter #(
    parameter int BYTES_PER_WORD = 4,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [15:0]                 clks_per_bit_i,
    input  logic                        tx_valid_i,
    input  logic [31:0]                 tx_word_i,
    output logic                        tx_ready_o,
    output logic                        tx_serial_o,
    output logic                        tx_active_o,
    output logic                        tx_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic [1:0]                  state_o
);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [1:0]  LAST_BYTE  = 2'(BYTES_PER_WORD - 1);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_LEVEL  = (AW + 1)'(1);
    localparam logic [AW-1:0] ONE_PTR  = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Word FIFO.
    // Handshake: a word is transferred on a rising clk_i edge where
    // tx_valid_i and tx_ready_o are both high. tx_ready_o is a function of
    // the FIFO level only (never of tx_valid_i); a full FIFO refuses the
    // push even if the FSM pops in the same cycle.
    // ------------------------------------------------------------------
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign push  = tx_valid_i && !full;

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= tx_word_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ONE_PTR;
            if (pop)  rd_ptr_q <= rd_ptr_q + ONE_PTR;
            if (push && !pop) begin
                level_q <= level_q + ONE_LEVEL;
            end else if (pop && !push) begin
                level_q <= level_q - ONE_LEVEL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic        serial_q, serial_d;
    logic        done_q, done_d;

    logic [15:0] period_in;
    logic        bit_end;
    logic [7:0]  cur_byte;

    assign period_in = (clks_per_bit_i == 16'd0) ? 16'd1 : clks_per_bit_i;
    assign bit_end   = (cnt_q == period_q - 16'd1);
    assign cur_byte  = shift_q[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            period_q   <= 16'd1;
            bit_idx_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            serial_q   <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        serial_d   = serial_q;
        done_d     = 1'b0;
        pop        = 1'b0;
        // Bit-period counter: 0..period-1, restarting at every bit boundary.
        cnt_d      = bit_end ? 16'd0 : cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                cnt_d    = 16'd0;
                serial_d = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_cnt_d = 2'd0;
                    period_d   = period_in;
                    state_d    = START;
                    serial_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    serial_d  = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d  = STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = cur_byte[bit_idx_q + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        // Next byte of the same word follows with no idle gap.
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        shift_d    = {8'h00, shift_q[31:8]};
                        period_d   = period_in;
                        state_d    = START;
                        serial_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        if (!empty) begin
                            // Chain straight into the next queued word.
                            pop        = 1'b1;
                            shift_d    = mem_q[rd_ptr_q];
                            byte_cnt_d = 2'd0;
                            period_d   = period_in;
                            state_d    = START;
                            serial_d   = 1'b0;
                        end else begin
                            state_d  = IDLE;
                            serial_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    assign tx_ready_o   = !full;
    assign tx_serial_o  = serial_q;
    assign tx_active_o  = (state_q != IDLE);
    assign tx_done_o    = done_q;
    assign fifo_level_o = level_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_uart_word_transmitter.sv
// tb_uart_word_transmitter
//   Self-checking bench for uart_word_transmitter. Pushed words are split
//   into expected bytes on a queue; a line monitor decodes every frame with
//   its own timing model and compares against the queue.
module tb_uart_word_transmitter;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpb;
    logic        tx_valid;
    logic [31:0] tx_word;
    logic        tx_ready;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;
    logic [1:0]  level;
    logic [1:0]  state;

    always #5 clk = ~clk;

    uart_word_transmitter #(
        .BYTES_PER_WORD(4),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clks_per_bit_i(cpb),
        .tx_valid_i    (tx_valid),
        .tx_word_i     (tx_word),
        .tx_ready_o    (tx_ready),
        .tx_serial_o   (tx_serial),
        .tx_active_o   (tx_active),
        .tx_done_o     (tx_done),
        .fifo_level_o  (level),
        .state_o       (state)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_bad    = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          t_done   = 0;
    int          t_start  = 0;
    int          push_cyc = 0;
    int          mon_frames = 0;
    int          gap_sum  = 0;
    logic [15:0] cpb_at_edge = 16'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        cpb_at_edge <= cpb;
    end

    always @(negedge clk) begin
        if (!rst && tx_done === 1'b1) begin
            done_cnt++;
            t_done = cyc;
        end
    end

    // ---------------- line monitor ----------------
    initial begin : monitor
        int         p;
        int         gap;
        logic       frame_ok;
        logic       aborted;
        logic       bitval;
        logic [7:0] data;
        gap = 0;
        bitval = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap = 0;
            end else if (tx_serial === 1'b0) begin
                p = (cpb_at_edge == 16'd0) ? 1 : int'(cpb_at_edge);
                if (mon_frames == 0) t_start = cyc;
                else gap_sum += gap;
                gap      = 0;
                frame_ok = 1'b1;
                aborted  = 1'b0;
                data     = 8'h00;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < p && !aborted; c++) begin
                        if (!(b == 0 && c == 0)) begin
                            @(negedge clk);
                            if (rst) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (c == 0) bitval = tx_serial;
                            else if (tx_serial !== bitval) frame_ok = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        if (b == 0 && bitval !== 1'b0) frame_ok = 1'b0;
                        if (b >= 1 && b <= 8) data[b-1] = bitval;
                        if (b == 9 && bitval !== 1'b1) frame_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    mon_frames++;
                    check("frame_ok", 32'(frame_ok), 32'd1);
                    check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("byte_value", 32'(data), 32'(exp_q.pop_front()));
                end
            end else begin
                gap++;
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push_word(input logic [31:0] w);
        int guard;
        guard    = 0;
        tx_valid = 1'b1;
        tx_word  = w;
        while (!tx_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", 32'(tx_ready), 32'd1);
        push_cyc = cyc + 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = (exp_q.size() == 0) && !tx_active && (level == 2'd0);
        end
        check("idle_reached", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int   done0;
        int   frames0;
        int   guard;

        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_word  = 32'hDEADBEEF;
        cpb      = 16'd4;

        // 1. reset held 3 cycles with valid high
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(tx_serial), 32'd1);
        check("rst_level",  32'(level),     32'd0);
        check("rst_ready",  32'(tx_ready),  32'd1);
        check("rst_active", 32'(tx_active), 32'd0);
        check("rst_done",   32'(tx_done),   32'd0);
        check("rst_state",  32'(state),     32'd0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_line",  32'(tx_serial), 32'd1);
        check("post_rst_level", 32'(level),     32'd0);

        // 2. single word at period 4
        cpb        = 16'd4;
        mon_frames = 0;
        done0      = done_cnt;
        push_word(32'hA5C30F81);
        tx_valid = 1'b0;
        wait_idle(1000);
        check("w1_done_pulses", 32'(done_cnt - done0),  32'd1);
        check("w1_start_lat",   32'(t_start - push_cyc), 32'd1);
        check("w1_duration",    32'(t_done - t_start),   32'd160);

        // 3. back-to-back words at period 2, valid held high
        cpb        = 16'd2;
        mon_frames = 0;
        gap_sum    = 0;
        done0      = done_cnt;
        push_word(32'h11223344);
        push_word(32'hCAFEF00D);
        push_word(32'h0055AAFF);
        check("b2b_full_level", 32'(level),    32'd2);
        check("b2b_full_ready", 32'(tx_ready), 32'd0);
        tx_word = 32'h87654321;
        guard   = 0;
        while (!tx_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        // the pop that frees a slot must not have taken the held word too
        check("b2b_refuse_level", 32'(level), 32'd1);
        push_word(32'h87654321);
        tx_valid = 1'b0;
        wait_idle(1000);
        check("b2b_done_pulses", 32'(done_cnt - done0), 32'd4);
        check("b2b_no_gap",      32'(gap_sum),          32'd0);
        check("b2b_frames",      32'(mon_frames),       32'd16);

        // 4a. clks_per_bit = 0 acts as 1
        cpb        = 16'd0;
        mon_frames = 0;
        push_word(32'($urandom));
        tx_valid = 1'b0;
        wait_idle(500);
        check("cpb0_duration", 32'(t_done - t_start), 32'd40);

        // 4b. change 4 -> 8 in the middle of byte 0
        cpb        = 16'd4;
        mon_frames = 0;
        push_word(32'h5A3CC3A5);
        tx_valid = 1'b0;
        repeat (12) @(negedge clk);
        cpb = 16'd8;
        wait_idle(1000);
        check("cpb_change_duration", 32'(t_done - t_start), 32'd280);

        // 5. reset during DATA bit 3 of byte 2 with a second word queued
        cpb        = 16'd4;
        mon_frames = 0;
        push_word(32'h0BADF00D);
        push_word(32'h13579BDF);
        tx_valid = 1'b0;
        repeat (97) @(negedge clk);
        check("pre_rst_state", 32'(state), 32'd2);
        check("pre_rst_level", 32'(level), 32'd1);
        done0 = done_cnt;
        rst   = 1'b1;
        @(negedge clk);
        check("mid_rst_line",   32'(tx_serial), 32'd1);
        check("mid_rst_level",  32'(level),     32'd0);
        check("mid_rst_active", 32'(tx_active), 32'd0);
        check("mid_rst_ready",  32'(tx_ready),  32'd1);
        rst = 1'b0;
        exp_q.delete();
        frames0 = mon_frames;
        repeat (100) @(negedge clk);
        check("mid_rst_no_done",   32'(done_cnt - done0),    32'd0);
        check("mid_rst_no_frames", 32'(mon_frames - frames0), 32'd0);
        check("mid_rst_line_idle", 32'(tx_serial),           32'd1);
        mon_frames = 0;
        push_word(32'hFEEDC0DE);
        tx_valid = 1'b0;
        wait_idle(1000);
        check("after_rst_done",   32'(done_cnt - done0), 32'd1);
        check("after_rst_frames", 32'(mon_frames),       32'd4);

        // 6. eight random words at period 16
        cpb        = 16'd16;
        mon_frames = 0;
        gap_sum    = 0;
        done0      = done_cnt;
        for (int i = 0; i < 8; i++) push_word(32'($urandom));
        tx_valid = 1'b0;
        wait_idle(8000);
        check("rand_done_pulses", 32'(done_cnt - done0), 32'd8);
        check("rand_frames",      32'(mon_frames),       32'd32);
        check("rand_no_gap",      32'(gap_sum),          32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
